// File: rtl/sample_streamer.sv
// Sample streamer: plays a DEPTH x N sample buffer out to a FIR data input, one sample per accept.
// Latency: first sample valid one cycle after start; one sample per cycle at full throughput.
// Backpressure: data_out/out_valid hold while out_ready=0; the read address advances only on accept.
//
// Ports: clk/reset (sync, active-high); wr_en/wr_addr/wr_data load the buffer in any state;
// last_addr (latched at start) bounds a pass; start/stop control playback; data_out/out_valid/out_ready
// form the output handshake; busy is high in PLAY; done pulses during the accept of the last sample.
// Build option: define STREAMER_LOOP_EN to replay the buffer continuously (done pulses every pass)
// instead of stopping after a single pass.
module sample_streamer #(
    parameter int N     = 16,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic [AW-1:0] last_addr,
    input  logic          start,
    input  logic          stop,
    input  logic          out_ready,
    output logic [N-1:0]  data_out,
    output logic          out_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_addr, addr_d;
    logic [AW-1:0] last_q;
    logic          valid_d;
    logic          load;
    logic          done_c;
    logic          accept;
    logic          at_last;

    logic [N-1:0]  mem [DEPTH];

    // Buffer write port. Contents survive reset; reset only blocks a same-cycle write.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign accept  = out_valid && out_ready;
    assign at_last = (rd_addr == last_q);

    // Next-state and datapath control. data_out is a register loaded only when a new
    // address is presented, so a write to the address on display cannot disturb it.
    always_comb begin
        state_d = state_q;
        addr_d  = rd_addr;
        valid_d = out_valid;
        load    = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                // stop has priority over a simultaneous start
                if (start && !stop) begin
                    state_d = PLAY;
                    addr_d  = '0;
                    valid_d = 1'b1;
                    load    = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    valid_d = 1'b0;
                end else if (accept) begin
                    if (at_last) begin
                        done_c = 1'b1;
                        addr_d = '0;
`ifdef STREAMER_LOOP_EN
                        load   = 1'b1;
`else
                        state_d = IDLE;
                        valid_d = 1'b0;
`endif
                    end else begin
                        addr_d = rd_addr + AW'(1);
                        load   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_addr   <= '0;
            last_q    <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr   <= addr_d;
            out_valid <= valid_d;
            if (load) begin
                data_out <= mem[addr_d];
            end
            // last_addr is only sampled on the IDLE->PLAY edge; later changes wait for the next start
            if (state_q == IDLE && state_d == PLAY) begin
                last_q <= last_addr;
            end
        end
    end

    assign busy = (state_q == PLAY);
    // done is high during the accept cycle of the final sample; a stop or reset in that cycle wins
    assign done = done_c && !reset;

endmodule

// File: doc/sample_streamer.md
SAMPLE_STREAMER -- requirements
Module: sample_streamer

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning sample buffer entries (address width 5 bits).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port wr_en  input  1  buffer write strobe.
REQ-006 The block SHALL have port wr_addr  input  5  buffer write address.
REQ-007 The block SHALL have port wr_data  input  N  buffer write data.
REQ-008 The block SHALL have port last_addr  input  5  final buffer address of a pass.
REQ-009 The block SHALL have port start  input  1  begin playback from address 0.
REQ-010 The block SHALL have port stop  input  1  abort playback.
REQ-011 The block SHALL have port out_ready  input  1  downstream (FIR data_in side) accepts sample.
REQ-012 The block SHALL have port data_out  output  N  current sample to the FIR filter.
REQ-013 The block SHALL have port out_valid  output  1  data_out holds a valid sample.
REQ-014 The block SHALL have port busy  output  1  state is PLAY.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse at end of pass.

Function
REQ-016 The block SHALL hold a DEPTH x N buffer written synchronously when wr_en=1, in any state.
REQ-017 The block SHALL implement FSM states IDLE and PLAY.
REQ-018 IDLE->PLAY SHALL occur on start=1 and stop=0; last_addr SHALL be latched on that edge.
REQ-019 out_valid SHALL rise one cycle after the start edge, with data_out=mem[0].
REQ-020 A sample SHALL be accepted on a cycle with out_valid=1 and out_ready=1; the read address then advances by 1 and the next data_out/out_valid appear on the following edge (one sample per cycle at full throughput).
REQ-021 data_out and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Acceptance of latched last_addr SHALL end the pass; last_addr=0 SHALL give a one-sample pass.
REQ-023 last_addr changes during PLAY SHALL have no effect until the next start.
REQ-024 A write to the address currently presented SHALL NOT change data_out; the value takes effect at the next read of that address.
REQ-025 stop=1 in PLAY SHALL force IDLE on the next edge with out_valid=0, done=0, and the address cleared to 0.
REQ-026 start and stop both 1 SHALL be treated as stop; start=1 during PLAY SHALL be ignored.
REQ-027 busy SHALL equal 1 exactly when state is PLAY.

Reset
REQ-028 reset=1 on a rising edge SHALL set state IDLE, address 0, data_out 0, out_valid 0, busy 0, done 0.
REQ-029 Reset SHALL NOT clear buffer contents, and SHALL override start, stop and wr_en in the same cycle.
REQ-030 Reset mid-PLAY SHALL drop out_valid on the next edge with no done pulse.

Configuration
REQ-031 Macro STREAMER_LOOP_EN defined: on acceptance of last_addr, the address SHALL wrap to 0, PLAY SHALL continue, and done SHALL pulse for that one cycle (every pass).
REQ-032 Macro STREAMER_LOOP_EN undefined: on acceptance of last_addr, the FSM SHALL go to IDLE, out_valid SHALL drop, and done SHALL pulse one cycle (single pass).

Verification
REQ-033 The bench SHALL cover: load mem[i]=i+1 for i=0..31, last_addr=31, start, out_ready=1 -> data_out 1..32 on 32 consecutive cycles, done pulse coincident with the accept of value 32.
REQ-034 The bench SHALL cover: out_ready held 0 for 3 cycles while presenting value 5 -> data_out=5 and out_valid=1 stable throughout, value 6 follows one cycle after ready returns.
REQ-035 The bench SHALL cover: last_addr=0, start -> one sample mem[0], done pulse; with LOOP_EN, mem[0] repeats every cycle with done each cycle.
REQ-036 The bench SHALL cover: stop asserted after 10 accepts -> out_valid=0 next cycle, no done; the next start restarts at mem[0].
REQ-037 The bench SHALL cover: with LOOP_EN and last_addr=31 -> after value 32, data_out wraps to 1; writing mem[0]=16'hABCD mid-pass -> 16'hABCD appears at the next wrap.
REQ-038 The bench SHALL cover: reset pulsed mid-PLAY -> all outputs 0 next cycle; buffer contents intact on the following start.
